iob_ibus_dbus_arbiter: RTL and testbench
========================================

Name: iob_ibus_dbus_arbiter

Overview:
- Shares one IOb-native memory port between the core's instruction bus (requester I) and data bus (requester D).
- Sits between the VexRiscv wrapper's ibus/dbus ports and a single-ported memory or external-memory interface.
- Arbitrates requests and locks the grant until a request is accepted. Allows one outstanding read at a time and routes the read response back to the requester that issued it.
- Adds zero cycles of request latency; request and response fields pass through combinationally.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; strobe width is DATA_W/8.
- FIXED_PRIO, 0. 0 = round-robin between I and D; 1 = D always wins ties.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- cke_i  in  1  clock enable
- ibus_avalid_i  in  1  I request valid
- ibus_addr_i  in  ADDR_W  I address
- ibus_wdata_i  in  DATA_W  I write data
- ibus_wstrb_i  in  DATA_W/8  I byte strobes; 0 = read
- ibus_ready_o  out  1  I request accepted this cycle
- ibus_rvalid_o  out  1  I read data valid
- ibus_rdata_o  out  DATA_W  I read data
- dbus_avalid_i, dbus_addr_i, dbus_wdata_i, dbus_wstrb_i, dbus_ready_o, dbus_rvalid_o, dbus_rdata_o: same as the ibus ports, for D
- mem_avalid_o  out  1  shared port request valid
- mem_addr_o  out  ADDR_W  shared address
- mem_wdata_o  out  DATA_W  shared write data
- mem_wstrb_o  out  DATA_W/8  shared strobes
- mem_ready_i  in  1  memory accepts request
- mem_rvalid_i  in  1  memory read data valid
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values (and forced while rst_i=1):
  - state = IDLE; last_grant = I, so D wins the first tie; lock = 0.
  - mem_avalid_o, ibus/dbus_ready_o and ibus/dbus_rvalid_o are all 0.
- cke_i=0: all registers hold. mem_avalid_o, both ready_o and both rvalid_o are forced to 0.
- States:
  - IDLE: requests may be granted.
  - RD_I: read outstanding for I.
  - RD_D: read outstanding for D.
- Grant selection in IDLE:
  - If lock=1, the grant equals the locked requester.
  - Else with one avalid set, grant that requester.
  - Else with both set: FIXED_PRIO=1 picks D; FIXED_PRIO=0 picks the requester that is not last_grant.
- Request path in IDLE:
  - mem_* fields are muxed from the granted requester. mem_avalid_o = granted avalid.
  - granted ready_o = mem_ready_i; non-granted ready_o = 0.
- Lock:
  - Set when mem_avalid_o=1 and mem_ready_i=0. Holds the grant so requester fields stay stable per IOb rules.
  - Cleared on acceptance (mem_avalid_o & mem_ready_i).
  - A competing request never preempts a locked one.
- On acceptance:
  - last_grant <= granted requester.
  - If mem_wstrb_o==0 (read), next state is RD_I or RD_D per the grant.
  - Writes stay in IDLE, so back-to-back writes are possible every cycle.
- RD_x states:
  - mem_avalid_o = 0 and both ready_o = 0.
  - x_rdata_o = mem_rdata_i, x_rvalid_o = mem_rvalid_i; the other rvalid_o = 0.
  - On mem_rvalid_i=1, next state is IDLE. The next grant is no earlier than the cycle after rvalid (one bubble).
- rdata_o outside a matching RD_x state drives mem_rdata_i, but rvalid_o stays 0.
- mem_rvalid_i in IDLE, including in the acceptance cycle, is ignored; no rvalid_o is asserted.
- Reset during RD_x returns to IDLE and abandons the read. A late mem_rvalid_i after reset is ignored.
- A requester dropping avalid while not locked is legal. A locked requester dropping avalid is a protocol violation; behaviour is unspecified, but lock clears when mem_avalid_o falls.

Test Plan:
- I read at 0x100, mem_ready_i=1, mem_rvalid_i two cycles later with 0xDEADBEEF -> ibus_ready_o=1 in the request cycle; state RD_I; ibus_rvalid_o=1 with ibus_rdata_o=0xDEADBEEF; dbus_rvalid_o stays 0.
- After reset, FIXED_PRIO=0, I and D both read in the same cycle -> D granted; ibus_ready_o=0 until the cycle after D's rvalid, then I granted and completes.
- I and D both issue continuous writes (wstrb=0xF), mem_ready_i=1, FIXED_PRIO=0 -> acceptances alternate D,I,D,I every cycle; mem_addr_o alternates accordingly.
- I write with mem_ready_i=0 for 3 cycles, D raises avalid in cycle 2 -> mem_addr_o stays I's address; I accepted in cycle 4; D accepted in cycle 5.
- D read accepted, rst_i pulsed before memory responds, mem_rvalid_i=1 with 0x12345678 two cycles later -> dbus_rvalid_o and ibus_rvalid_o stay 0; state IDLE; next I request accepted normally.
- FIXED_PRIO=1, both issue continuous writes for 8 cycles with mem_ready_i=1 -> 8 D acceptances, ibus_ready_o=0 throughout. cke_i=0 for one cycle -> mem_avalid_o=0 and state unchanged.

Source files
------------

// File: rtl/iob_ibus_dbus_arbiter.sv
// iob_ibus_dbus_arbiter
// Shares one IOb-native memory port between the instruction bus (I) and the
// data bus (D). Requests and responses pass through combinationally. Once the
// shared port shows a request, the grant stays on that requester until it is
// accepted. Only one read may be outstanding at a time. Its response is routed
// back to the requester that issued it.
//
// Ports:
//   clk_i, rst_i, cke_i         clock, synchronous active-high reset, clock enable
//   ibus_*_i / ibus_*_o         requester I: avalid, addr, wdata, wstrb, ready, rvalid, rdata
//   dbus_*_i / dbus_*_o         requester D: same fields as I
//   mem_*_o / mem_*_i           shared port: avalid, addr, wdata, wstrb, ready, rvalid, rdata
//
// state | meaning
// IDLE  | requests may be granted
// RD_I  | read outstanding for I
// RD_D  | read outstanding for D
module iob_ibus_dbus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cke_i,
    input  logic                ibus_avalid_i,
    input  logic [ADDR_W-1:0]   ibus_addr_i,
    input  logic [DATA_W-1:0]   ibus_wdata_i,
    input  logic [DATA_W/8-1:0] ibus_wstrb_i,
    output logic                ibus_ready_o,
    output logic                ibus_rvalid_o,
    output logic [DATA_W-1:0]   ibus_rdata_o,
    input  logic                dbus_avalid_i,
    input  logic [ADDR_W-1:0]   dbus_addr_i,
    input  logic [DATA_W-1:0]   dbus_wdata_i,
    input  logic [DATA_W/8-1:0] dbus_wstrb_i,
    output logic                dbus_ready_o,
    output logic                dbus_rvalid_o,
    output logic [DATA_W-1:0]   dbus_rdata_o,
    output logic                mem_avalid_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_wstrb_o,
    input  logic                mem_ready_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   lock_q, lock_d;
    logic   lock_grant_q, lock_grant_d;
    logic   grant;
    logic   active;
    logic   accept;

    // Outputs are silenced while in reset or while the clock is not enabled.
    assign active = cke_i & ~rst_i;

    always_comb begin
        grant = GNT_I;
        if (lock_q) begin
            grant = lock_grant_q;
        end else if (ibus_avalid_i && !dbus_avalid_i) begin
            grant = GNT_I;
        end else if (!ibus_avalid_i && dbus_avalid_i) begin
            grant = GNT_D;
        end else if (ibus_avalid_i && dbus_avalid_i) begin
            grant = (FIXED_PRIO != 0) ? GNT_D : ~last_grant_q;
        end
    end

    assign mem_addr_o   = (grant == GNT_D) ? dbus_addr_i  : ibus_addr_i;
    assign mem_wdata_o  = (grant == GNT_D) ? dbus_wdata_i : ibus_wdata_i;
    assign mem_wstrb_o  = (grant == GNT_D) ? dbus_wstrb_i : ibus_wstrb_i;
    assign mem_avalid_o = active && (state_q == IDLE) &&
                          ((grant == GNT_D) ? dbus_avalid_i : ibus_avalid_i);
    assign accept       = mem_avalid_o & mem_ready_i;

    assign ibus_ready_o  = accept && (grant == GNT_I);
    assign dbus_ready_o  = accept && (grant == GNT_D);
    assign ibus_rvalid_o = active && (state_q == RD_I) && mem_rvalid_i;
    assign dbus_rvalid_o = active && (state_q == RD_D) && mem_rvalid_i;
    assign ibus_rdata_o  = mem_rdata_i;
    assign dbus_rdata_o  = mem_rdata_i;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_d       = lock_q;
        lock_grant_d = lock_grant_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = grant;
                    lock_d       = 1'b0;
                    if (mem_wstrb_o == '0) begin
                        state_d = (grant == GNT_D) ? RD_D : RD_I;
                    end
                end else if (mem_avalid_o) begin
                    lock_d       = 1'b1;
                    lock_grant_d = grant;
                end else begin
                    // Covers a locked requester withdrawing its request.
                    lock_d = 1'b0;
                end
            end
            RD_I, RD_D: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
            lock_q       <= 1'b0;
            lock_grant_q <= GNT_I;
        end else if (cke_i) begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_grant_q <= lock_grant_d;
        end
    end

endmodule

// File: tb/tb_iob_ibus_dbus_arbiter.sv
// Testbench for iob_ibus_dbus_arbiter: a round-robin instance is checked
// against a table of per-cycle vectors, and a fixed-priority instance is
// checked with a hand-written sequence. Both instances share the stimulus.
module tb_iob_ibus_dbus_arbiter;

    localparam logic [31:0] I_ADDR  = 32'h0000_0100;
    localparam logic [31:0] D_ADDR  = 32'h0000_0200;
    localparam logic [31:0] I_WDATA = 32'hAAAA_0001;
    localparam logic [31:0] D_WDATA = 32'hBBBB_0002;

    logic        clk = 1'b0;
    logic        rst, cke;
    logic        ibus_avalid, dbus_avalid;
    logic [3:0]  ibus_wstrb, dbus_wstrb;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;

    logic        i_rdy0, i_rv0, d_rdy0, d_rv0, m_av0;
    logic [31:0] i_rd0, d_rd0, m_addr0, m_wd0;
    logic [3:0]  m_ws0;
    logic        i_rdy1, i_rv1, d_rdy1, d_rv1, m_av1;
    logic [31:0] i_rd1, d_rd1, m_addr1, m_wd1;
    logic [3:0]  m_ws1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    iob_ibus_dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut_rr (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .ibus_avalid_i(ibus_avalid), .ibus_addr_i(I_ADDR), .ibus_wdata_i(I_WDATA),
        .ibus_wstrb_i(ibus_wstrb), .ibus_ready_o(i_rdy0), .ibus_rvalid_o(i_rv0),
        .ibus_rdata_o(i_rd0),
        .dbus_avalid_i(dbus_avalid), .dbus_addr_i(D_ADDR), .dbus_wdata_i(D_WDATA),
        .dbus_wstrb_i(dbus_wstrb), .dbus_ready_o(d_rdy0), .dbus_rvalid_o(d_rv0),
        .dbus_rdata_o(d_rd0),
        .mem_avalid_o(m_av0), .mem_addr_o(m_addr0), .mem_wdata_o(m_wd0),
        .mem_wstrb_o(m_ws0), .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    iob_ibus_dbus_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
        .clk_i(clk), .rst_i(rst), .cke_i(cke),
        .ibus_avalid_i(ibus_avalid), .ibus_addr_i(I_ADDR), .ibus_wdata_i(I_WDATA),
        .ibus_wstrb_i(ibus_wstrb), .ibus_ready_o(i_rdy1), .ibus_rvalid_o(i_rv1),
        .ibus_rdata_o(i_rd1),
        .dbus_avalid_i(dbus_avalid), .dbus_addr_i(D_ADDR), .dbus_wdata_i(D_WDATA),
        .dbus_wstrb_i(dbus_wstrb), .dbus_ready_o(d_rdy1), .dbus_rvalid_o(d_rv1),
        .dbus_rdata_o(d_rd1),
        .mem_avalid_o(m_av1), .mem_addr_o(m_addr1), .mem_wdata_o(m_wd1),
        .mem_wstrb_o(m_ws1), .mem_ready_i(mem_ready), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    typedef struct {
        logic        rst, cke, iav;
        logic [3:0]  iws;
        logic        dav;
        logic [3:0]  dws;
        logic        mrdy, mrv;
        logic [31:0] rdata;
        logic        e_mav;
        logic [31:0] e_maddr;
        logic        e_ird, e_drd, e_irv, e_drv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic c, logic ia, logic [3:0] iw, logic da,
                                logic [3:0] dw, logic mr, logic mv, logic [31:0] rd,
                                logic emav, logic [31:0] ema, logic eir, logic edr,
                                logic eiv, logic edv);
        vec_t v;
        v.rst = r; v.cke = c; v.iav = ia; v.iws = iw; v.dav = da; v.dws = dw;
        v.mrdy = mr; v.mrv = mv; v.rdata = rd;
        v.e_mav = emav; v.e_maddr = ema; v.e_ird = eir; v.e_drd = edr;
        v.e_irv = eiv; v.e_drv = edv;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive at the falling edge; the caller samples 1 ns later, well before
    // the next rising edge.
    task automatic apply(vec_t v);
        @(negedge clk);
        rst = v.rst; cke = v.cke; ibus_avalid = v.iav; ibus_wstrb = v.iws;
        dbus_avalid = v.dav; dbus_wstrb = v.dws; mem_ready = v.mrdy;
        mem_rvalid = v.mrv; mem_rdata = v.rdata;
        #1;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; cke = 1'b1; ibus_avalid = 1'b0; dbus_avalid = 1'b0;
        ibus_wstrb = 4'h0; dbus_wstrb = 4'h0; mem_ready = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        //          rst cke iav iws  dav dws  rdy rv rdata        mav addr   ird drd irv drv
        vecs.push_back(mk(1, 1, 1, 4'h0, 1, 4'h0, 1, 1, 32'h11,       0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h0, 0, 4'h0, 1, 0, 32'h0,        1, I_ADDR, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 1, 4'hF, 1, 0, 32'h0,        0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 1, 1, 32'hDEADBEEF, 0, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 32'h0,        0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h0, 1, 4'h0, 1, 0, 32'h0,        1, D_ADDR, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h0, 0, 4'h0, 1, 0, 32'h0,        0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h0, 0, 4'h0, 1, 1, 32'hCAFE0001, 0, 32'h0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 4'h0, 0, 4'h0, 1, 0, 32'h0,        1, I_ADDR, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 1, 1, 32'h0BADF00D, 0, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 1, 1, 32'h77,       0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'hF, 1, 4'hF, 1, 0, 32'h0,        1, D_ADDR, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'hF, 1, 4'hF, 1, 0, 32'h0,        1, I_ADDR, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'hF, 1, 4'hF, 1, 1, 32'h99,       1, D_ADDR, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'hF, 1, 4'hF, 1, 0, 32'h0,        1, I_ADDR, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'hF, 0, 4'h0, 0, 0, 32'h0,        1, I_ADDR, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'hF, 1, 4'hF, 0, 0, 32'h0,        1, I_ADDR, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'hF, 1, 4'hF, 0, 0, 32'h0,        1, I_ADDR, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'hF, 1, 4'hF, 1, 0, 32'h0,        1, I_ADDR, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 1, 4'hF, 1, 0, 32'h0,        1, D_ADDR, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 32'h0,        1, D_ADDR, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 4'h0, 0, 4'h0, 1, 0, 32'h0,        0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 1, 1, 32'h12345678, 0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'h0, 0, 4'h0, 1, 0, 32'h0,        1, I_ADDR, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 4'h0, 1, 1, 32'h5,        0, 32'h0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 4'hF, 1, 4'hF, 1, 1, 32'h6,        0, 32'h0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'hF, 1, 4'hF, 1, 0, 32'h0,        1, D_ADDR, 0, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v);
            chk($sformatf("v%0d mem_avalid", i), {31'b0, m_av0}, {31'b0, v.e_mav});
            chk($sformatf("v%0d ibus_ready", i), {31'b0, i_rdy0}, {31'b0, v.e_ird});
            chk($sformatf("v%0d dbus_ready", i), {31'b0, d_rdy0}, {31'b0, v.e_drd});
            chk($sformatf("v%0d ibus_rvalid", i), {31'b0, i_rv0}, {31'b0, v.e_irv});
            chk($sformatf("v%0d dbus_rvalid", i), {31'b0, d_rv0}, {31'b0, v.e_drv});
            chk($sformatf("v%0d ibus_rdata", i), i_rd0, v.rdata);
            chk($sformatf("v%0d dbus_rdata", i), d_rd0, v.rdata);
            if (v.e_mav) begin
                chk($sformatf("v%0d mem_addr", i), m_addr0, v.e_maddr);
                chk($sformatf("v%0d mem_wdata", i), m_wd0,
                    (v.e_maddr == I_ADDR) ? I_WDATA : D_WDATA);
                chk($sformatf("v%0d mem_wstrb", i), {28'b0, m_ws0},
                    {28'b0, (v.e_maddr == I_ADDR) ? v.iws : v.dws});
            end
        end

        // Fixed priority: D wins every tie, I never gets the port.
        apply(mk(1, 1, 0, 4'h0, 0, 4'h0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        chk("fp reset mem_avalid", {31'b0, m_av1}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            apply(mk(0, 1, 1, 4'hF, 1, 4'hF, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
            chk($sformatf("fp w%0d mem_avalid", k), {31'b0, m_av1}, 32'd1);
            chk($sformatf("fp w%0d mem_addr", k), m_addr1, D_ADDR);
            chk($sformatf("fp w%0d dbus_ready", k), {31'b0, d_rdy1}, 32'd1);
            chk($sformatf("fp w%0d ibus_ready", k), {31'b0, i_rdy1}, 32'd0);
        end
        apply(mk(0, 0, 1, 4'hF, 1, 4'hF, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        chk("fp cke0 mem_avalid", {31'b0, m_av1}, 32'd0);
        chk("fp cke0 dbus_ready", {31'b0, d_rdy1}, 32'd0);
        // D read, then a stalled cycle with rvalid: the read must still be pending.
        apply(mk(0, 1, 0, 4'h0, 1, 4'h0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        chk("fp rd accept dbus_ready", {31'b0, d_rdy1}, 32'd1);
        apply(mk(0, 0, 1, 4'hF, 0, 4'h0, 1, 1, 32'h0A0A0A0A, 0, 0, 0, 0, 0, 0));
        chk("fp rd cke0 dbus_rvalid", {31'b0, d_rv1}, 32'd0);
        apply(mk(0, 1, 1, 4'hF, 0, 4'h0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        chk("fp rd pending mem_avalid", {31'b0, m_av1}, 32'd0);
        chk("fp rd pending ibus_ready", {31'b0, i_rdy1}, 32'd0);
        apply(mk(0, 1, 1, 4'hF, 0, 4'h0, 1, 1, 32'h5A5A5A5A, 0, 0, 0, 0, 0, 0));
        chk("fp rd dbus_rvalid", {31'b0, d_rv1}, 32'd1);
        chk("fp rd ibus_rvalid", {31'b0, i_rv1}, 32'd0);
        chk("fp rd dbus_rdata", d_rd1, 32'h5A5A5A5A);
        apply(mk(0, 1, 1, 4'hF, 1, 4'hF, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0));
        chk("fp after rd mem_addr", m_addr1, D_ADDR);
        chk("fp after rd dbus_ready", {31'b0, d_rdy1}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
